// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one byte-level UART transmitter among NREQ requesters; optional UART_ARB_LOCK_EN keeps grant for a whole message.
// Latency: req sampled at one edge gives tx_valid/grant after that edge; ack pulses the cycle after the tx handshake.
// Backpressure: tx_valid/tx_data held until tx_ready; requesters hold req/req_data until ack, updating them in the ack cycle.
module uart_tx_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    grant,
    output logic               tx_valid,
    output logic [DW-1:0]      tx_data,
    input  logic               tx_ready,
    output logic               busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
`ifdef UART_ARB_LOCK_EN
        , HOLD = 2'd2
`endif
    } state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] owner_nxt;
    logic [PW-1:0] win_idx;
    logic          found;
    int unsigned   cand;

    // First requesting index at or after rr_ptr, wrapping NREQ-1 -> 0.
    always_comb begin
        win_idx = rr_ptr;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = PW'(cand);
            end
        end
    end

    assign owner_nxt = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;

`ifndef UART_ARB_LOCK_EN
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            grant    <= '0;
            ack      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= NREQ'(1) << win_idx;
                        owner    <= win_idx;
                        tx_data  <= req_data[int'(win_idx)*DW +: DW];
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        ack      <= grant;
                        tx_valid <= 1'b0;
`ifdef UART_ARB_LOCK_EN
                        if (!req_last[owner]) begin
                            state <= HOLD;
                        end else begin
                            grant  <= '0;
                            rr_ptr <= owner_nxt;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end
`else
                        grant  <= '0;
                        rr_ptr <= owner_nxt;
                        busy   <= 1'b0;
                        state  <= IDLE;
`endif
                    end
                end
`ifdef UART_ARB_LOCK_EN
                // Locked to the owner: other requesters wait until its last byte.
                HOLD: begin
                    if (req[owner]) begin
                        tx_data  <= req_data[int'(owner)*DW +: DW];
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
`endif
                default: begin
                    grant    <= '0;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: requester queues drive req, a scoreboard checks every handshake and ack pulse.
module tb_uart_tx_arb;
    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    ack;
    logic [NREQ-1:0]    grant;
    logic               tx_valid;
    logic [DW-1:0]      tx_data;
    logic               tx_ready;
    logic               busy;

    always #5 clk = ~clk;

    uart_tx_arb #(.NREQ(NREQ), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_data(req_data),
        .req_last(req_last), .ack(ack), .grant(grant), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy)
    );

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] dat;
    } exp_t;

    typedef struct {
        logic [3:0]      mask;
        int              nb;
        logic [7:0]      base;
        bit              rnd;
        int              cnt;
        logic [7:0][1:0] ord;
    } vec_t;

    int              n_cmp = 0;
    int              n_fail = 0;
    exp_t            sb[$];
    logic [8:0]      rq[0:NREQ-1][$];
    logic [NREQ-1:0] exp_ack = '0;
    logic [NREQ-1:0] nxt_ack;
    logic [NREQ-1:0] force_low = '0;
    logic            rdy_level = 1'b0;
    logic            rdy_rand = 1'b0;
    exp_t            e_hs;
    vec_t            vt[0:5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic bit rq_empty();
        bit e = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            done = (sb.size() == 0) && (exp_ack == '0) && rq_empty();
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: timeout with %0d bytes outstanding, want 0", name, sb.size());
            sb.delete();
            for (int i = 0; i < NREQ; i++) rq[i].delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Requester model: drops the acked byte in the ack cycle, presents the next one.
    initial begin
        req = '0;
        req_data = '0;
        req_last = '0;
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i] && rq[i].size() > 0) rq[i].delete(0);
                if (rq[i].size() > 0) begin
                    req[i] = !force_low[i];
                    req_data[i*DW +: DW] = rq[i][0][7:0];
                    req_last[i] = rq[i][0][8];
                end else begin
                    req[i] = 1'b0;
                    req_data[i*DW +: DW] = '0;
                    req_last[i] = 1'b0;
                end
            end
            tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
        end
    end

    // Monitor: each handshake must match the scoreboard head; ack must follow exactly once.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_ack = '0;
        end else begin
            if (exp_ack != '0 || ack != '0) chk("ack_pulse", 32'(ack), 32'(exp_ack));
`ifndef UART_ARB_LOCK_EN
            if (ack != '0) chk("grant_clear_on_ack", 32'(grant), 32'd0);
`endif
            nxt_ack = '0;
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_handshake: got grant %0h data %0h want none", grant, tx_data);
                end else begin
                    e_hs = sb.pop_front();
                    chk("hs_grant", 32'(grant), 32'(1) << e_hs.idx);
                    chk("hs_data", 32'(tx_data), 32'(e_hs.dat));
                    nxt_ack = NREQ'(1) << e_hs.idx;
                end
            end
            exp_ack = nxt_ack;
        end
    end

    initial begin
        int occ[0:NREQ-1];
        logic [7:0] d;
        int ix;

        // ord lists the expected winners, element 0 rightmost.
        vt[0] = '{4'b1111, 2, 8'h00, 1'b0, 8, {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}};
        vt[1] = '{4'b0100, 1, 8'h21, 1'b0, 1, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2}};
        vt[2] = '{4'b1001, 1, 8'h80, 1'b0, 2, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3}};
        vt[3] = '{4'b0101, 1, 8'h05, 1'b0, 2, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2}};
        vt[4] = '{4'b1010, 2, 8'h07, 1'b1, 4, {2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd3, 2'd1}};
        vt[5] = '{4'b0001, 3, 8'h0A, 1'b0, 3, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}};

        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            rdy_level = 1'b1;
            rdy_rand = vt[v].rnd;
            for (int i = 0; i < NREQ; i++) begin
                occ[i] = 0;
                if (vt[v].mask[i]) begin
                    for (int b = 0; b < vt[v].nb; b++) begin
                        d = vt[v].base + 8'(16 * i) + 8'(b);
                        rq[i].push_back({1'b1, d});
                    end
                end
            end
            for (int k = 0; k < vt[v].cnt; k++) begin
                ix = int'(vt[v].ord[k]);
                d = vt[v].base + 8'(16 * ix) + 8'(occ[ix]);
                sb.push_back({2'(ix), d});
                occ[ix]++;
            end
            wait_done($sformatf("vec%0d", v));
            rdy_rand = 1'b0;
        end

        // Stalled transmitter: one-cycle latency, byte held stable, single ack.
        rdy_level = 1'b0;
        rq[0].push_back({1'b1, 8'h55});
        sb.push_back({2'd0, 8'h55});
        @(negedge clk);
        chk("lat_before", 32'(tx_valid), 32'd0);
        @(negedge clk);
        chk("lat_grant", 32'(grant), 32'b0001);
        for (int c = 0; c < 10; c++) begin
            chk("stall_valid", 32'(tx_valid), 32'd1);
            chk("stall_data", 32'(tx_data), 32'h55);
            chk("stall_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        rdy_level = 1'b1;
        wait_done("stall");

        // Message of three bytes from requester 1 competing with requester 0.
        rq[1].push_back({1'b0, 8'h91});
        rq[1].push_back({1'b0, 8'h92});
        rq[1].push_back({1'b1, 8'h93});
        rq[0].push_back({1'b1, 8'h90});
`ifdef UART_ARB_LOCK_EN
        sb.push_back({2'd1, 8'h91});
        sb.push_back({2'd1, 8'h92});
        sb.push_back({2'd1, 8'h93});
        sb.push_back({2'd0, 8'h90});
`else
        sb.push_back({2'd1, 8'h91});
        sb.push_back({2'd0, 8'h90});
        sb.push_back({2'd1, 8'h92});
        sb.push_back({2'd1, 8'h93});
`endif
        wait_done("message");

        // Winner withdraws req mid-transfer; captured byte still goes out.
        rdy_level = 1'b0;
        rq[3].push_back({1'b1, 8'h3C});
        sb.push_back({2'd3, 8'h3C});
        repeat (2) @(negedge clk);
        force_low[3] = 1'b1;
        repeat (3) @(negedge clk);
        chk("withdraw_valid", 32'(tx_valid), 32'd1);
        chk("withdraw_data", 32'(tx_data), 32'h3C);
        rdy_level = 1'b1;
        wait_done("withdraw");
        force_low = '0;

        // Reset during SEND: byte dropped, arbitration restarts from requester 0.
        rq[2].push_back({1'b1, 8'h22});
        sb.push_back({2'd2, 8'h22});
        wait_done("pre_reset");
        rdy_level = 1'b0;
        rq[1].push_back({1'b1, 8'h11});
        rq[3].push_back({1'b1, 8'h33});
        sb.push_back({2'd3, 8'h33});
        sb.push_back({2'd1, 8'h11});
        repeat (2) @(negedge clk);
        chk("pre_reset_grant", 32'(grant), 32'b1000);
        reset_n = 1'b0;
        #1;
        chk("arst_tx_valid", 32'(tx_valid), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_tx_data", 32'(tx_data), 32'd0);
        sb.delete();
        sb.push_back({2'd1, 8'h11});
        sb.push_back({2'd3, 8'h33});
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rdy_level = 1'b1;
        wait_done("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
